// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS pipeline definitions.
//  DATA_W     - default datapath width
//  REG_ADDR_W - register-file address width
//  wb_ctrl_t  - writeback control bundle carried by every pipeline register
package mips_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef struct packed {
        logic RegWrite;
        logic MemtoReg;
    } wb_ctrl_t;

endpackage

// File: rtl/data_mem.sv
// data_mem: single-port word RAM, asynchronous read, synchronous write.
// Ports:
//  CLK      in  clock, rising edge
//  i_we     in  write enable
//  i_addr   in  word index
//  i_wdata  in  write data
//  o_rdata  out read data (combinational, pre-write value during a write cycle)
// Contents have no reset.
module data_mem #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MIPS MEM stage (data memory) plus MEM/WB pipeline register.
// Ports:
//  CLK, reset (async, active-low)
//  ALUResultM  byte address for loads/stores, or R-type result
//  WriteDataM  store data
//  WriteRegM, RegWriteM, MemtoRegM, MemWriteM  M-stage destination and control
//  ReadDataW, ALUResultW, WriteRegW, RegWriteW, MemtoRegW  registered W-stage values
//  ResultW     writeback mux output (combinational)
//  MisalignErr sticky misalignment flag
// Optional feature: define MEM_ALIGN_CHECK_EN to suppress misaligned stores and flag
// misaligned accesses on MisalignErr; otherwise low address bits are ignored and
// MisalignErr is tied to 0.
module mem_wb_stage #(
    parameter int unsigned DATA_W = mips_pkg::DATA_W,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                            CLK,
    input  logic                            reset,
    input  logic [DATA_W-1:0]               ALUResultM,
    input  logic [DATA_W-1:0]               WriteDataM,
    input  logic [mips_pkg::REG_ADDR_W-1:0] WriteRegM,
    input  logic                            RegWriteM,
    input  logic                            MemtoRegM,
    input  logic                            MemWriteM,
    output logic [DATA_W-1:0]               ReadDataW,
    output logic [DATA_W-1:0]               ALUResultW,
    output logic [mips_pkg::REG_ADDR_W-1:0] WriteRegW,
    output logic                            RegWriteW,
    output logic                            MemtoRegW,
    output logic [DATA_W-1:0]               ResultW,
    output logic                            MisalignErr
);

    import mips_pkg::*;

    logic [ADDR_W-1:0] w_idx;
    logic [DATA_W-1:0] w_rd;
    logic              w_misal;
    logic              w_we;

    logic [DATA_W-1:0]     r_read_data;
    logic [DATA_W-1:0]     r_alu_result;
    logic [REG_ADDR_W-1:0] r_write_reg;
    wb_ctrl_t              r_ctrl;

    // Word index; upper address bits dropped so accesses wrap modulo DEPTH.
    assign w_idx = ALUResultM[ADDR_W+1:2];

`ifdef MEM_ALIGN_CHECK_EN
    logic r_misalign_err;

    assign w_misal = |ALUResultM[1:0];

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_misalign_err <= 1'b0;
        end else if ((MemWriteM | MemtoRegM) & w_misal) begin
            r_misalign_err <= 1'b1;
        end
    end

    assign MisalignErr = r_misalign_err;
`else
    assign w_misal     = 1'b0;
    assign MisalignErr = 1'b0;
`endif

    // Stores are blocked while reset is held, and when misaligned (check enabled).
    assign w_we = MemWriteM & reset & ~w_misal;

    data_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_data_mem (
        .CLK     (CLK),
        .i_we    (w_we),
        .i_addr  (w_idx),
        .i_wdata (WriteDataM),
        .o_rdata (w_rd)
    );

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_read_data  <= '0;
            r_alu_result <= '0;
            r_write_reg  <= '0;
            r_ctrl       <= '0;
        end else begin
            r_read_data     <= w_rd;
            r_alu_result    <= ALUResultM;
            r_write_reg     <= WriteRegM;
            r_ctrl.RegWrite <= RegWriteM;
            r_ctrl.MemtoReg <= MemtoRegM;
        end
    end

    assign ReadDataW  = r_read_data;
    assign ALUResultW = r_alu_result;
    assign WriteRegW  = r_write_reg;
    assign RegWriteW  = r_ctrl.RegWrite;
    assign MemtoRegW  = r_ctrl.MemtoReg;
    assign ResultW    = r_ctrl.MemtoReg ? r_read_data : r_alu_result;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: scoreboard bench for mem_wb_stage. Each issued M-stage vector pushes
// its expected W-stage values; a monitor pops and compares one entry after each edge.
module tb_mem_wb_stage;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit AlignEn = 1'b1;
`else
    localparam bit AlignEn = 1'b0;
`endif

    typedef struct {
        logic        chk_rd;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wreg;
        logic        rw;
        logic        m2r;
        logic [31:0] res;
    } exp_t;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ALUResultM = '0;
    logic [31:0] WriteDataM = '0;
    logic [4:0]  WriteRegM = '0;
    logic        RegWriteM = 1'b0;
    logic        MemtoRegM = 1'b0;
    logic        MemWriteM = 1'b0;
    logic [31:0] ReadDataW;
    logic [31:0] ALUResultW;
    logic [4:0]  WriteRegW;
    logic        RegWriteW;
    logic        MemtoRegW;
    logic [31:0] ResultW;
    logic        MisalignErr;

    int   total = 0;
    int   bad = 0;
    exp_t q[$];

    mem_wb_stage u_dut (
        .CLK         (CLK),
        .reset       (reset),
        .ALUResultM  (ALUResultM),
        .WriteDataM  (WriteDataM),
        .WriteRegM   (WriteRegM),
        .RegWriteM   (RegWriteM),
        .MemtoRegM   (MemtoRegM),
        .MemWriteM   (MemWriteM),
        .ReadDataW   (ReadDataW),
        .ALUResultW  (ALUResultW),
        .WriteRegW   (WriteRegW),
        .RegWriteW   (RegWriteW),
        .MemtoRegW   (MemtoRegW),
        .ResultW     (ResultW),
        .MisalignErr (MisalignErr)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: W outputs are valid one edge after the vector was presented.
    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.chk_rd) chk("ReadDataW", ReadDataW, e.rd);
            chk("ALUResultW", ALUResultW, e.alu);
            chk("WriteRegW", {27'd0, WriteRegW}, {27'd0, e.wreg});
            chk("RegWriteW", {31'd0, RegWriteW}, {31'd0, e.rw});
            chk("MemtoRegW", {31'd0, MemtoRegW}, {31'd0, e.m2r});
            chk("ResultW", ResultW, e.res);
        end
    end

    // Present one M-stage vector and queue the W-stage values it must produce.
    task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic [4:0] wr,
                        input logic rw, input logic m2r, input logic mw,
                        input logic chk_rd, input logic [31:0] exp_rd);
        exp_t e;
        @(negedge CLK);
        ALUResultM = a;
        WriteDataM = wd;
        WriteRegM  = wr;
        RegWriteM  = rw;
        MemtoRegM  = m2r;
        MemWriteM  = mw;
        e.chk_rd = chk_rd;
        e.rd     = exp_rd;
        e.alu    = a;
        e.wreg   = wr;
        e.rw     = rw;
        e.m2r    = m2r;
        e.res    = m2r ? exp_rd : a;
        q.push_back(e);
        @(posedge CLK);
    endtask

    task automatic chk_w_zero(input string tag);
        chk({tag, " ReadDataW"}, ReadDataW, 32'd0);
        chk({tag, " ALUResultW"}, ALUResultW, 32'd0);
        chk({tag, " WriteRegW"}, {27'd0, WriteRegW}, 32'd0);
        chk({tag, " RegWriteW"}, {31'd0, RegWriteW}, 32'd0);
        chk({tag, " MemtoRegW"}, {31'd0, MemtoRegW}, 32'd0);
        chk({tag, " ResultW"}, ResultW, 32'd0);
        chk({tag, " MisalignErr"}, {31'd0, MisalignErr}, 32'd0);
    endtask

    initial begin
        #2 reset = 1'b0;
        #2 chk_w_zero("por");
        @(negedge CLK);
        reset = 1'b1;

        // Store then load.
        step(32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        step(32'h10, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
        // R-type pass-through.
        step(32'h1234, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        // Address wrap: 0x400 and 0x800 alias word 0.
        step(32'h400, 32'hA5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        step(32'h0, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA5);
        step(32'h800, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA5);
        // Same-cycle collision, also a store with RegWrite set.
        step(32'hC, 32'h1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        step(32'hC, 32'h2, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1);
        step(32'hC, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 32'h2);

        // Async reset mid-cycle with non-zero W outputs and a store presented.
        #3;
        reset      = 1'b0;
        ALUResultM = 32'hC;
        WriteDataM = 32'h77;
        MemWriteM  = 1'b1;
        #1 chk_w_zero("async_rst");
        @(posedge CLK);
        @(negedge CLK);
        MemWriteM = 1'b0;
        reset     = 1'b1;
        step(32'hC, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 32'h2);

        // Misaligned store to word 8.
        step(32'h20, 32'h55, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        step(32'h21, 32'hFF, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h55);
        #1 chk("MisalignErr set", {31'd0, MisalignErr}, {31'd0, AlignEn});
        step(32'h20, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, AlignEn ? 32'h55 : 32'hFF);
        step(32'h40, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        #1 chk("MisalignErr sticky", {31'd0, MisalignErr}, {31'd0, AlignEn});
        #1 reset = 1'b0;
        #1 chk("MisalignErr reset", {31'd0, MisalignErr}, 32'd0);
        @(negedge CLK);
        reset = 1'b1;
        @(posedge CLK);
        #2;
        chk("scoreboard drained", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
